// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: op-select enum, opcode/funct constants and
// field-packing helpers used by both the encoder and decoder sides.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        SEL_ADD   = 5'd0,
        SEL_ADDU  = 5'd1,
        SEL_SUB   = 5'd2,
        SEL_SUBU  = 5'd3,
        SEL_AND   = 5'd4,
        SEL_OR    = 5'd5,
        SEL_NOR   = 5'd6,
        SEL_SLT   = 5'd7,
        SEL_SLTU  = 5'd8,
        SEL_SLL   = 5'd9,
        SEL_SRL   = 5'd10,
        SEL_LW    = 5'd11,
        SEL_SW    = 5'd12,
        SEL_BEQ   = 5'd13,
        SEL_J     = 5'd14,
        SEL_ADDI  = 5'd15,
        SEL_ADDIU = 5'd16,
        SEL_ANDI  = 5'd17,
        SEL_ORI   = 5'd18,
        SEL_SLTI  = 5'd19,
        SEL_SLTIU = 5'd20
    } op_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opcode, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: turns an op select plus operand fields into a
// 32-bit MIPS instruction word, flagging op selects outside the ISA subset.
module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the encoding format and opcode/funct for the requested op.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            SEL_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
            SEL_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
            SEL_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
            SEL_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
            SEL_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
            SEL_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
            SEL_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
            SEL_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
            SEL_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
            SEL_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            SEL_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
            SEL_LW:    word = i_word(OP_LW, rs, rt, imm);
            SEL_SW:    word = i_word(OP_SW, rs, rt, imm);
            SEL_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
            SEL_J:     word = {OP_J, target};
            SEL_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
            SEL_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
            SEL_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
            SEL_ORI:   word = i_word(OP_ORI, rs, rt, imm);
            SEL_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
            SEL_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instruction requests over valid/ready,
// encodes them and writes them sequentially into instruction memory.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic              full_arm;
    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic [ADDR_W:0]   count_inc;

    mips_word_pack u_pack (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // Count after the write currently in flight completes.
    always_comb begin
        count_inc = count + 1'b1;
    end

    // Session FSM with registered handshake, status and write-port outputs.
    // full_arm marks the single DONE-entry cycle after the memory filled up
    // without a last flag; a legal request seen then raises err_full.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= BASE_PTR;
            count       <= '0;
            last_q      <= 1'b0;
            full_arm    <= 1'b0;
            op_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            imem_we  <= 1'b0;
            full_arm <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        ptr         <= BASE_PTR;
                        count       <= '0;
                        err_illegal <= 1'b0;
                        err_full    <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        op_ready    <= 1'b1;
                    end else if (state == S_DONE && full_arm && op_valid && !pack_illegal) begin
                        err_full <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (op_valid) begin
                        last_q <= last;
                        if (pack_illegal) begin
                            err_illegal <= 1'b1;
                            if (last) begin
                                state    <= S_DONE;
                                op_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end
                        end else if (count == DEPTH_C) begin
                            err_full <= 1'b1;
                            state    <= S_DONE;
                            op_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state      <= S_WRITE;
                            op_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= ptr;
                            imem_wdata <= pack_word;
                        end
                    end
                end
                S_WRITE: begin
                    ptr   <= ptr + 1'b1;
                    count <= count_inc;
                    if (last_q || count_inc == DEPTH_C) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        full_arm <= !last_q;
                    end else begin
                        state    <= S_LOAD;
                        op_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
